// File: rtl/mdu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_ctrl_pkg
//  Description : Shared definitions for the MDU sequencer. Holds the 4-bit
//                MDU opcode set used by the decoder, hazard unit and
//                sequencer. It also holds the sequencer state type and
//                opcode classification helpers.
//  Config      : MDU_MADD_EN - when defined, MADD/MADDU/MSUB/MSUBU are
//                accepted as multi-cycle operations; otherwise those codes
//                behave like MDU_NONE.
//  Revision    : 1.0 - initial release
// ============================================================================
package mdu_ctrl_pkg;

   // MDU opcodes (4 bits, MDU_NONE must stay 0)
   localparam logic [3:0] c_MDU_NONE  = 4'd0;
   localparam logic [3:0] c_MDU_MULT  = 4'd1;
   localparam logic [3:0] c_MDU_MULTU = 4'd2;
   localparam logic [3:0] c_MDU_DIV   = 4'd3;
   localparam logic [3:0] c_MDU_DIVU  = 4'd4;
   localparam logic [3:0] c_MDU_MFHI  = 4'd5;
   localparam logic [3:0] c_MDU_MFLO  = 4'd6;
   localparam logic [3:0] c_MDU_MTHI  = 4'd7;
   localparam logic [3:0] c_MDU_MTLO  = 4'd8;
   localparam logic [3:0] c_MDU_MADD  = 4'd9;
   localparam logic [3:0] c_MDU_MADDU = 4'd10;
   localparam logic [3:0] c_MDU_MSUB  = 4'd11;
   localparam logic [3:0] c_MDU_MSUBU = 4'd12;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } mdu_state_e;

   // True for every opcode that launches a busy countdown.
   function automatic logic mdu_is_start(input logic [3:0] op);
      logic r;
      case (op)
         c_MDU_MULT, c_MDU_MULTU, c_MDU_DIV, c_MDU_DIVU: r = 1'b1;
`ifdef MDU_MADD_EN
         c_MDU_MADD, c_MDU_MADDU, c_MDU_MSUB, c_MDU_MSUBU: r = 1'b1;
`endif
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   // Divides use the long latency, everything else the multiply latency.
   function automatic logic mdu_is_div(input logic [3:0] op);
      return (op == c_MDU_DIV) || (op == c_MDU_DIVU);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_ctrl_calc.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_ctrl_calc
//  Description : Combinational MDU datapath. Produces the 64-bit {hi,lo}
//                result of a mult/div (and, when enabled, multiply-
//                accumulate) operation from the operands at start time.
//  Config      : MDU_MADD_EN - enables the MADD/MADDU/MSUB/MSUBU arms.
//  Ports       : i_op          opcode being started
//                i_rs, i_rt    operands
//                i_hi, i_lo    current architectural HI/LO (accumulate base)
//                o_hi, o_lo    result to be committed
//                o_we          0 when the result must not be committed (div0)
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_ctrl_calc
   import mdu_ctrl_pkg::*;
(
   input  logic [3:0]  i_op,
   input  logic [31:0] i_rs,
   input  logic [31:0] i_rt,
   input  logic [31:0] i_hi,
   input  logic [31:0] i_lo,
   output logic [31:0] o_hi,
   output logic [31:0] o_lo,
   output logic        o_we
);

   logic [63:0] w_acc;
   logic [63:0] w_prod_s;
   logic [63:0] w_prod_u;
   logic [63:0] w_res;
   logic        w_div0;
   logic        w_ovf;
   logic [31:0] w_div_s;
   logic [31:0] w_div_u;
   logic [31:0] w_q_s;
   logic [31:0] w_r_s;
   logic [31:0] w_q_u;
   logic [31:0] w_r_u;

   assign w_acc    = {i_hi, i_lo};
   assign w_prod_s = $signed({{32{i_rs[31]}}, i_rs}) * $signed({{32{i_rt[31]}}, i_rt});
   assign w_prod_u = {32'd0, i_rs} * {32'd0, i_rt};

   assign w_div0 = (i_rt == 32'd0);
   assign w_ovf  = (i_rs == 32'h8000_0000) && (i_rt == 32'hFFFF_FFFF);

   // Substituting a divisor of 1 for the overflow case yields exactly the
   // required quotient 0x80000000 / remainder 0 without a signed overflow.
   // A zero divisor is also replaced so the divider never sees 0; its result
   // is discarded through o_we.
   assign w_div_s = (w_div0 || w_ovf) ? 32'd1 : i_rt;
   assign w_div_u = w_div0 ? 32'd1 : i_rt;

   assign w_q_s = $signed(i_rs) / $signed(w_div_s);
   assign w_r_s = $signed(i_rs) % $signed(w_div_s);
   assign w_q_u = i_rs / w_div_u;
   assign w_r_u = i_rs % w_div_u;

   always_comb begin
      w_res = w_acc;
      o_we  = 1'b0;
      case (i_op)
         c_MDU_MULT: begin
            w_res = w_prod_s;
            o_we  = 1'b1;
         end
         c_MDU_MULTU: begin
            w_res = w_prod_u;
            o_we  = 1'b1;
         end
         c_MDU_DIV: begin
            w_res = {w_r_s, w_q_s};
            o_we  = !w_div0;
         end
         c_MDU_DIVU: begin
            w_res = {w_r_u, w_q_u};
            o_we  = !w_div0;
         end
`ifdef MDU_MADD_EN
         c_MDU_MADD: begin
            w_res = w_acc + w_prod_s;
            o_we  = 1'b1;
         end
         c_MDU_MADDU: begin
            w_res = w_acc + w_prod_u;
            o_we  = 1'b1;
         end
         c_MDU_MSUB: begin
            w_res = w_acc - w_prod_s;
            o_we  = 1'b1;
         end
         c_MDU_MSUBU: begin
            w_res = w_acc - w_prod_u;
            o_we  = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   assign o_hi = w_res[63:32];
   assign o_lo = w_res[31:0];

endmodule
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_ctrl
//  Description : Multi-cycle multiply/divide sequencer owning HI/LO. Starts
//                MDU ops from E stage, holds a busy countdown of MUL_LAT or
//                DIV_LAT cycles, commits the pending result on the last busy
//                cycle and serves mfhi/mflo data back to E. Requests a D-stage
//                stall for any MDU instruction while busy or starting.
//  Config      : MDU_MADD_EN - enables multiply-accumulate opcodes.
//  Ports       : clk, reset     clock / async active-high reset
//                E_MDU_op       E-stage MDU opcode
//                E_rs_data      rs operand (also MTHI/MTLO data)
//                E_rt_data      rt operand
//                D_MDU_use      D-stage instruction uses the MDU
//                E_HI_LO        mfhi/mflo read data (combinational)
//                MDU_busy       countdown active (registered)
//                MDU_stall      D-stage stall request (combinational)
//                HI, LO         architectural HI/LO
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_ctrl
   import mdu_ctrl_pkg::*;
#(
   parameter int MUL_LAT = 5,
   parameter int DIV_LAT = 10
)(
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  E_MDU_op,
   input  logic [31:0] E_rs_data,
   input  logic [31:0] E_rt_data,
   input  logic        D_MDU_use,
   output logic [31:0] E_HI_LO,
   output logic        MDU_busy,
   output logic        MDU_stall,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int c_MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int c_CNT_W   = $clog2(c_MAX_LAT + 1);

   mdu_state_e         r_state;
   logic [c_CNT_W-1:0] r_count;
   logic               r_busy;
   logic [31:0]        r_hi;
   logic [31:0]        r_lo;
   logic [31:0]        r_pend_hi;
   logic [31:0]        r_pend_lo;
   logic               r_pend_we;

   logic               w_start;
   logic [c_CNT_W-1:0] w_lat;
   logic [31:0]        w_res_hi;
   logic [31:0]        w_res_lo;
   logic               w_res_we;

   mdu_ctrl_calc u_calc (
      .i_op (E_MDU_op),
      .i_rs (E_rs_data),
      .i_rt (E_rt_data),
      .i_hi (r_hi),
      .i_lo (r_lo),
      .o_hi (w_res_hi),
      .o_lo (w_res_lo),
      .o_we (w_res_we)
   );

   // An MDU op arriving while busy is a hazard-unit violation and is dropped.
   assign w_start = mdu_is_start(E_MDU_op) && (r_state == ST_IDLE);
   assign w_lat   = mdu_is_div(E_MDU_op) ? c_CNT_W'(DIV_LAT) : c_CNT_W'(MUL_LAT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_count   <= '0;
         r_busy    <= 1'b0;
         r_hi      <= 32'd0;
         r_lo      <= 32'd0;
         r_pend_hi <= 32'd0;
         r_pend_lo <= 32'd0;
         r_pend_we <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_state   <= ST_BUSY;
                  r_busy    <= 1'b1;
                  r_count   <= w_lat;
                  r_pend_hi <= w_res_hi;
                  r_pend_lo <= w_res_lo;
                  r_pend_we <= w_res_we;
               end else if (E_MDU_op == c_MDU_MTHI) begin
                  r_hi <= E_rs_data;
               end else if (E_MDU_op == c_MDU_MTLO) begin
                  r_lo <= E_rs_data;
               end
            end
            ST_BUSY: begin
               r_count <= r_count - c_CNT_W'(1);
               // Last busy cycle: commit so the result is readable next cycle.
               if (r_count == c_CNT_W'(1)) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  if (r_pend_we) begin
                     r_hi <= r_pend_hi;
                     r_lo <= r_pend_lo;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      E_HI_LO = 32'd0;
      if (E_MDU_op == c_MDU_MFHI) begin
         E_HI_LO = r_hi;
      end else if (E_MDU_op == c_MDU_MFLO) begin
         E_HI_LO = r_lo;
      end
   end

   assign MDU_busy  = r_busy;
   assign MDU_stall = D_MDU_use && (r_busy || w_start);
   assign HI        = r_hi;
   assign LO        = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdu_ctrl
//  Description : Self-checking bench for mdu_ctrl. A cycle-stamped reference
//                model predicts busy/stall/read-data/HI/LO each cycle; a
//                negedge process compares, and directed scenarios add
//                hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_ctrl;
   import mdu_ctrl_pkg::*;

   localparam int MUL_LAT = 5;
   localparam int DIV_LAT = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  E_MDU_op;
   logic [31:0] E_rs_data;
   logic [31:0] E_rt_data;
   logic        D_MDU_use;
   logic [31:0] E_HI_LO;
   logic        MDU_busy;
   logic        MDU_stall;
   logic [31:0] HI;
   logic [31:0] LO;

   mdu_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
      .clk       (clk),
      .reset     (reset),
      .E_MDU_op  (E_MDU_op),
      .E_rs_data (E_rs_data),
      .E_rt_data (E_rt_data),
      .D_MDU_use (D_MDU_use),
      .E_HI_LO   (E_HI_LO),
      .MDU_busy  (MDU_busy),
      .MDU_stall (MDU_stall),
      .HI        (HI),
      .LO        (LO)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: architectural HI/LO plus one in-flight operation
   // described by the cycle number at which its result becomes visible.
   logic [31:0] m_hi, m_lo, m_pend_hi, m_pend_lo;
   bit          m_pend_we, m_active;
   int          m_done, cyc_n;

   logic [31:0] exp_hilo, exp_hi, exp_lo;
   logic        exp_busy, exp_stall;
   bit          chk_en = 1'b0;
   int          busy_cnt = 0, stall_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit model_is_start(input logic [3:0] op);
      case (op)
         c_MDU_MULT, c_MDU_MULTU, c_MDU_DIV, c_MDU_DIVU: return 1'b1;
`ifdef MDU_MADD_EN
         c_MDU_MADD, c_MDU_MADDU, c_MDU_MSUB, c_MDU_MSUBU: return 1'b1;
`endif
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_launch(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
      longint      sp;
      logic [63:0] up, acc, res;
      sp  = longint'($signed(rs)) * longint'($signed(rt));
      up  = 64'(rs) * 64'(rt);
      acc = {m_hi, m_lo};
      res = acc;
      m_pend_we = 1'b1;
      case (op)
         c_MDU_MULT:  res = sp;
         c_MDU_MULTU: res = up;
         c_MDU_DIV: begin
            if (rt == 32'd0) m_pend_we = 1'b0;
            else if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) res = {32'd0, 32'h8000_0000};
            else res = {32'(int'(rs) % int'(rt)), 32'(int'(rs) / int'(rt))};
         end
         c_MDU_DIVU: begin
            if (rt == 32'd0) m_pend_we = 1'b0;
            else res = {rs % rt, rs / rt};
         end
         c_MDU_MADD:  res = acc + sp;
         c_MDU_MADDU: res = acc + up;
         c_MDU_MSUB:  res = acc - sp;
         c_MDU_MSUBU: res = acc - up;
         default: ;
      endcase
      {m_pend_hi, m_pend_lo} = res;
      m_active = 1'b1;
      m_done   = cyc_n + 1 + ((op == c_MDU_DIV || op == c_MDU_DIVU) ? DIV_LAT : MUL_LAT);
   endtask

   // One clock cycle: drive inputs, publish expectations, advance the model.
   task automatic cyc(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                      input logic duse);
      bit st;
      E_MDU_op  = op;
      E_rs_data = rs;
      E_rt_data = rt;
      D_MDU_use = duse;
      exp_busy  = m_active && (cyc_n < m_done);
      st        = model_is_start(op) && !exp_busy;
      exp_stall = duse && (exp_busy || st);
      exp_hilo  = (op == c_MDU_MFHI) ? m_hi : (op == c_MDU_MFLO) ? m_lo : 32'd0;
      exp_hi    = m_hi;
      exp_lo    = m_lo;
      chk_en    = 1'b1;
      @(posedge clk);
      if (m_active && (cyc_n + 1 == m_done)) begin
         m_active = 1'b0;
         if (m_pend_we) begin
            m_hi = m_pend_hi;
            m_lo = m_pend_lo;
         end
      end
      if (st) model_launch(op, rs, rt);
      else if (!exp_busy && op == c_MDU_MTHI) m_hi = rs;
      else if (!exp_busy && op == c_MDU_MTLO) m_lo = rs;
      cyc_n++;
      #1;
   endtask

   task automatic idle(input int n, input logic duse);
      for (int i = 0; i < n; i++) cyc(c_MDU_NONE, 32'd0, 32'd0, duse);
   endtask

   task automatic model_clear();
      m_hi = 32'd0; m_lo = 32'd0; m_pend_hi = 32'd0; m_pend_lo = 32'd0;
      m_pend_we = 1'b0; m_active = 1'b0; m_done = 0; cyc_n = 0;
   endtask

   // Single compare process.
   always @(negedge clk) begin
      if (chk_en) begin
         check("busy",  32'(MDU_busy),  32'(exp_busy));
         check("stall", 32'(MDU_stall), 32'(exp_stall));
         check("e_hilo", E_HI_LO, exp_hilo);
         check("hi", HI, exp_hi);
         check("lo", LO, exp_lo);
         if (MDU_busy)  busy_cnt++;
         if (MDU_stall) stall_cnt++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      model_clear();
      reset     = 1'b1;
      E_MDU_op  = c_MDU_MFHI;
      E_rs_data = 32'd0;
      E_rt_data = 32'd0;
      D_MDU_use = 1'b0;
      #3;
      check("rst_busy",  32'(MDU_busy), 32'd0);
      check("rst_hi",    HI, 32'd0);
      check("rst_lo",    LO, 32'd0);
      check("rst_ehilo", E_HI_LO, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;

      // 1: mult -3 * 7, busy cycles 1..5, MF* during busy read old values
      busy_cnt = 0;
      cyc(c_MDU_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
      for (int i = 1; i <= 5; i++) cyc((i % 2) ? c_MDU_MFHI : c_MDU_MFLO, 32'd0, 32'd0, 1'b0);
      check("t1_hi", HI, 32'hFFFF_FFFF);
      check("t1_lo", LO, 32'hFFFF_FFEB);
      check("t1_busy_cycles", 32'(busy_cnt), 32'd5);
      cyc(c_MDU_MFHI, 32'd0, 32'd0, 1'b1);
      cyc(c_MDU_MFLO, 32'd0, 32'd0, 1'b1);

      // 2: divu 100/7 with D_MDU_use held; stray ops while busy are ignored
      stall_cnt = 0;
      cyc(c_MDU_DIVU, 32'd100, 32'd7, 1'b1);
      for (int i = 1; i <= 10; i++)
         cyc((i == 4) ? c_MDU_MULT : (i == 7) ? c_MDU_MTHI : c_MDU_NONE, 32'd5, 32'd9, 1'b1);
      check("t2_lo", LO, 32'd14);
      check("t2_hi", HI, 32'd2);
      check("t2_stall_cycles", 32'(stall_cnt), 32'd11);
      cyc(c_MDU_MFLO, 32'd0, 32'd0, 1'b1);

      // 3: divide by zero leaves HI/LO untouched but still busies DIV_LAT
      cyc(c_MDU_MTHI, 32'hA, 32'd0, 1'b0);
      cyc(c_MDU_MTLO, 32'hB, 32'd0, 1'b0);
      busy_cnt = 0;
      cyc(c_MDU_DIV, 32'd5, 32'd0, 1'b0);
      idle(10, 1'b0);
      check("t3_hi", HI, 32'hA);
      check("t3_lo", LO, 32'hB);
      check("t3_busy_cycles", 32'(busy_cnt), 32'd10);

      // 4: signed overflow divide, unsigned square, signed negative divide
      cyc(c_MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      idle(10, 1'b0);
      check("t4_ovf_lo", LO, 32'h8000_0000);
      check("t4_ovf_hi", HI, 32'd0);
      cyc(c_MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      idle(5, 1'b0);
      check("t4_sq_hi", HI, 32'hFFFF_FFFE);
      check("t4_sq_lo", LO, 32'd1);
      cyc(c_MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
      idle(10, 1'b0);
      check("t4_neg_lo", LO, 32'hFFFF_FFFD);
      check("t4_neg_hi", HI, 32'hFFFF_FFFF);

      // 5: async reset during cycle 3 of a divide
      cyc(c_MDU_DIVU, 32'd100, 32'd7, 1'b0);
      idle(2, 1'b0);
      chk_en    = 1'b0;
      E_MDU_op  = c_MDU_NONE;
      D_MDU_use = 1'b0;
      reset     = 1'b1;
      #1;
      check("t5_busy", 32'(MDU_busy), 32'd0);
      check("t5_hi", HI, 32'd0);
      check("t5_lo", LO, 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      model_clear();
      idle(12, 1'b0);
      check("t5_no_commit_hi", HI, 32'd0);
      check("t5_no_commit_lo", LO, 32'd0);

      // 6: multiply-accumulate (or its absence)
      cyc(c_MDU_MTHI, 32'd0, 32'd0, 1'b0);
      cyc(c_MDU_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0);
      busy_cnt = 0;
      cyc(c_MDU_MADDU, 32'd1, 32'd1, 1'b1);
      idle(5, 1'b0);
`ifdef MDU_MADD_EN
      check("t6_hi", HI, 32'd1);
      check("t6_lo", LO, 32'd0);
      check("t6_busy_cycles", 32'(busy_cnt), 32'd5);
      cyc(c_MDU_MSUB, 32'd2, 32'hFFFF_FFFF, 1'b0);
      idle(5, 1'b0);
      check("t6_msub_hi", HI, 32'd1);
      check("t6_msub_lo", LO, 32'd2);
`else
      check("t6_hi", HI, 32'd0);
      check("t6_lo", LO, 32'hFFFF_FFFF);
      check("t6_busy_cycles", 32'(busy_cnt), 32'd0);
`endif
      idle(2, 1'b0);
      chk_en = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
